// File: rtl/deserializer.sv
// Serial-to-parallel receiver: shifts an MSB-first framed bitstream into a
// WIDTH-bit word, stages it in a holding register and offers it downstream
// over a req/ack handshake. Double-buffered so the next frame can shift in
// while the previous word waits for its acknowledge.
module deserializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } shift_state_t;

  typedef enum logic [1:0] {
    H_EMPTY,
    H_REQ,
    H_GAP
  } hs_state_t;

  shift_state_t     shift_state;
  hs_state_t        hs_state;
  // Only the last WIDTH-1 bits are ever needed: the completed word is these
  // bits plus the bit arriving on the completing edge.
  logic [WIDTH-2:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             full;

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             ack_now;
  logic             load;
  logic             drop;
  logic             full_next;

  // Word completion, handshake release and holding-register decisions
  always_comb begin
    word      = {shift_reg, din};
    word_done = (shift_state == S_SHIFT) && din_valid && !frame_start &&
                (bit_cnt == LAST_CNT);
    ack_now   = (hs_state == H_REQ) && out_ack;
    load      = word_done && (!full || ack_now);
    drop      = word_done && full && !ack_now;
    full_next = full;
    if (load) begin
      full_next = 1'b1;
    end else if (ack_now) begin
      full_next = 1'b0;
    end
  end

  // Shift FSM: frame detection, bit counting and restart detection
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_state <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (din_valid) begin
        shift_reg <= {shift_reg[WIDTH-3:0], din};
        case (shift_state)
          S_IDLE: begin
            if (frame_start) begin
              bit_cnt     <= CNT_W'(1);
              shift_state <= S_SHIFT;
              busy        <= 1'b1;
            end
          end
          S_SHIFT: begin
            if (frame_start) begin
              bit_cnt   <= CNT_W'(1);
              frame_err <= 1'b1;
            end else if (bit_cnt == LAST_CNT) begin
              bit_cnt     <= '0;
              shift_state <= S_IDLE;
              busy        <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: begin
            shift_state <= S_IDLE;
            bit_cnt     <= '0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  // Handshake FSM: holding register, request generation and overrun tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_state <= H_EMPTY;
      full     <= 1'b0;
      out_data <= '0;
      out_req  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      full <= full_next;
      if (load) begin
        out_data <= word;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
      // Transitions look at full_next so a word completing in EMPTY raises
      // out_req on the very edge it loads.
      case (hs_state)
        H_EMPTY: begin
          if (full_next) begin
            hs_state <= H_REQ;
            out_req  <= 1'b1;
          end
        end
        H_REQ: begin
          if (out_ack) begin
            hs_state <= H_GAP;
            out_req  <= 1'b0;
          end
        end
        H_GAP: begin
          if (full_next) begin
            hs_state <= H_REQ;
            out_req  <= 1'b1;
          end else begin
            hs_state <= H_EMPTY;
          end
        end
        default: begin
          hs_state <= H_EMPTY;
          out_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: framing, stalls, back-to-back words,
// overrun, mid-frame restart and reset behaviour.
module tb_deserializer;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             din;
  logic             din_valid;
  logic             frame_start;
  logic [WIDTH-1:0] out_data;
  logic             out_req;
  logic             out_ack;
  logic             busy;
  logic             overrun;
  logic             frame_err;

  int unsigned checks;
  int unsigned errors;

  deserializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_req     (out_req),
    .out_ack     (out_ack),
    .busy        (busy),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs, input logic ack);
    din         = b;
    din_valid   = 1'b1;
    frame_start = fs;
    out_ack     = ack;
    tick();
    din_valid   = 1'b0;
    frame_start = 1'b0;
    out_ack     = 1'b0;
    din         = 1'b0;
  endtask

  // Sends bits [31:32-nbits] of w MSB-first; frame_start on the first bit.
  task automatic send_bits(input logic [31:0] w, input int nbits, input bit fs,
                           input bit gaps, input bit ack_last);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[31-i], fs && (i == 0), ack_last && (i == nbits - 1));
      if (gaps && (i != nbits - 1)) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    out_ack     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_req", {31'b0, out_req}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    check("rst_frame_err", {31'b0, frame_err}, 32'h0);

    // 1: basic frame, ack one cycle after req
    send_bits(32'hA5C30F81, 31, 1'b1, 1'b0, 1'b0);
    check("t1_busy", {31'b0, busy}, 32'h1);
    check("t1_req_before", {31'b0, out_req}, 32'h0);
    send_bit(1'b1, 1'b0, 1'b0);
    check("t1_req", {31'b0, out_req}, 32'h1);
    check("t1_data", out_data, 32'hA5C30F81);
    check("t1_busy_done", {31'b0, busy}, 32'h0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("t1_req_after_ack", {31'b0, out_req}, 32'h0);
    tick();
    check("t1_req_idle", {31'b0, out_req}, 32'h0);
    check("t1_overrun", {31'b0, overrun}, 32'h0);

    // 2: pre-frame junk and stalls on alternate cycles
    do_reset();
    send_bits(32'hF8000000, 5, 1'b0, 1'b1, 1'b0);
    tick();
    check("t2_idle_busy", {31'b0, busy}, 32'h0);
    send_bits(32'hA5C30F81, 31, 1'b1, 1'b1, 1'b0);
    tick();
    check("t2_req_before", {31'b0, out_req}, 32'h0);
    send_bit(1'b1, 1'b0, 1'b0);
    check("t2_req", {31'b0, out_req}, 32'h1);
    check("t2_data", out_data, 32'hA5C30F81);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();

    // 3: back-to-back frames, ack lands on the second completion edge
    do_reset();
    send_bits(32'h12345678, 32, 1'b1, 1'b0, 1'b0);
    check("t3_req1", {31'b0, out_req}, 32'h1);
    check("t3_data1", out_data, 32'h12345678);
    send_bits(32'h9ABCDEF0, 32, 1'b1, 1'b0, 1'b1);
    check("t3_gap_req", {31'b0, out_req}, 32'h0);
    check("t3_data2_load", out_data, 32'h9ABCDEF0);
    tick();
    check("t3_req2", {31'b0, out_req}, 32'h1);
    check("t3_data2", out_data, 32'h9ABCDEF0);
    check("t3_overrun", {31'b0, overrun}, 32'h0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    check("t3_req_done", {31'b0, out_req}, 32'h0);

    // 4: no ack ever, overrun on second completion and sticky
    do_reset();
    send_bits(32'h11111111, 32, 1'b1, 1'b0, 1'b0);
    check("t4_data1", out_data, 32'h11111111);
    send_bits(32'h22222222, 31, 1'b1, 1'b0, 1'b0);
    check("t4_ovr_before", {31'b0, overrun}, 32'h0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("t4_ovr_set", {31'b0, overrun}, 32'h1);
    check("t4_data_held", out_data, 32'h11111111);
    send_bits(32'h33333333, 32, 1'b1, 1'b0, 1'b0);
    check("t4_ovr_sticky", {31'b0, overrun}, 32'h1);
    check("t4_data_held3", out_data, 32'h11111111);
    check("t4_req_held", {31'b0, out_req}, 32'h1);

    // 5: restart after 10 bits, then restart coinciding with the last bit
    do_reset();
    send_bits(32'hFFFFFFFF, 10, 1'b1, 1'b0, 1'b0);
    check("t5_ferr_quiet", {31'b0, frame_err}, 32'h0);
    send_bit(1'b0, 1'b1, 1'b0);
    check("t5_ferr_pulse", {31'b0, frame_err}, 32'h1);
    send_bits(32'h0001FFFF, 31, 1'b0, 1'b0, 1'b0);
    check("t5_ferr_clear", {31'b0, frame_err}, 32'h0);
    check("t5_req", {31'b0, out_req}, 32'h1);
    check("t5_data", out_data, 32'h0000FFFF);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    send_bits(32'hFFFFFFFF, 31, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    check("t5_last_restart_ferr", {31'b0, frame_err}, 32'h1);
    check("t5_last_restart_req", {31'b0, out_req}, 32'h0);
    check("t5_last_restart_busy", {31'b0, busy}, 32'h1);
    check("t5_last_restart_data", out_data, 32'h0000FFFF);

    // 6: reset mid-frame and while out_req is high
    do_reset();
    send_bits(32'hDEADBEEF, 20, 1'b1, 1'b0, 1'b0);
    do_reset();
    check("t6_busy", {31'b0, busy}, 32'h0);
    check("t6_req", {31'b0, out_req}, 32'h0);
    check("t6_data", out_data, 32'h0);
    send_bits(32'hBEEF0000, 12, 1'b0, 1'b0, 1'b0);
    tick();
    check("t6_tail_ignored", {31'b0, out_req}, 32'h0);
    send_bits(32'hCAFEF00D, 32, 1'b1, 1'b0, 1'b0);
    check("t6_fresh_req", {31'b0, out_req}, 32'h1);
    check("t6_fresh_data", out_data, 32'hCAFEF00D);
    do_reset();
    check("t6_req_rst", {31'b0, out_req}, 32'h0);
    check("t6_data_rst", out_data, 32'h0);
    tick();
    tick();
    check("t6_no_repost", {31'b0, out_req}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the packet serializer.
- Accumulates a serial bitstream into a WIDTH-bit packet word (MSB-first, framed by a start strobe), stages it in a holding register, and hands it to the downstream consumer over the req/ack bus handshake as the requester.
- Sits between the serial link and the packet-consuming logic.
- Double-buffered so the next frame can shift in while the previous word awaits acknowledge.

Parameters:
- WIDTH, 32, packet width in bits; must be a multiple of 8. Byte k = bits [8k+7:8k]; field3 = [31:24] … field0 = [7:0] at default.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this edge when high; low cycles are stalls, ignored.
- frame_start  input  1  qualifies the first bit of a frame; only meaningful with din_valid=1.
- out_data  output  WIDTH  holding-register contents; stable for as long as out_req=1.
- out_req  output  1  request: a complete word is presented on out_data.
- out_ack  input  1  responder acknowledge; sampled only while out_req=1.
- busy  output  1  shift FSM is in SHIFT (frame partially received).
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- frame_err  output  1  one-cycle pulse: frame_start arrived during a partial frame.

Behaviour:
Reset:
- Synchronous reset clears everything: shift_reg=0, bit_cnt=0, out_data=0, out_req=0, busy=0, overrun=0, frame_err=0.
- Shift FSM goes to IDLE; handshake FSM goes to EMPTY.
- Reset mid-frame or mid-handshake discards the partial frame and the held word; nothing is presented afterwards.

Shift FSM (IDLE, SHIFT):
- Bit sampling:
  - A bit is accepted on an edge with din_valid=1.
  - shift_reg <= {shift_reg[WIDTH-2:0], din}, so the first bit ends at the MSB.
- IDLE:
  - din_valid&&frame_start -> accept bit as bit 1, bit_cnt=1, go to SHIFT.
  - din_valid without frame_start -> bit discarded, stay IDLE.
- SHIFT:
  - Each accepted bit increments bit_cnt.
  - When the WIDTH-th bit is accepted, the word completes on that edge: completed word = {shift_reg[WIDTH-2:0], din}. Then bit_cnt=0 and the FSM returns to IDLE.
- frame_start with din_valid while in SHIFT:
  - Partial frame discarded.
  - Current bit taken as bit 1 of a new frame (bit_cnt=1, stays SHIFT).
  - frame_err pulses high for the next cycle.
- frame_start coinciding with the WIDTH-th bit: treated as a restart (frame_err pulse); no word completes.
- busy = (state==SHIFT).
- bit_cnt is $clog2(WIDTH)+1 bits wide and never exceeds WIDTH.

Handshake FSM (EMPTY, REQ, GAP), with holding flag full:
- Word completes and holding is free (full=0, or released by ack on the same edge):
  - out_data <= completed word, full=1.
- EMPTY:
  - full=1 -> REQ. out_req rises the cycle after the word completes (latency: last bit edge N -> out_req high from N+1).
- REQ:
  - out_req=1, out_data held stable.
  - Edge with out_ack=1 -> full cleared (unless reloaded on the same edge), go to GAP.
  - out_ack=0 -> stay in REQ indefinitely.
- GAP:
  - out_req=0 for exactly one cycle, so the responder sees a low between words.
  - Then -> REQ if full, else -> EMPTY.
- Overrun:
  - A word completes while full=1 and no ack lands on that edge -> new word dropped, out_data unchanged, overrun set.
  - overrun is sticky until rst.
- Completion on the same edge as ack: the new word loads, and the FSM goes GAP then REQ with the new data. Never an overrun.
- out_ack while out_req=0 is ignored.
- Minimum word spacing on the link is WIDTH cycles; in steady state, acks returned within WIDTH-2 cycles guarantee no overrun.

Test Plan:
1. Reset, then frame_start + 32 bits of 0xA5C30F81 MSB-first, din_valid=1 every cycle, out_ack one cycle after out_req -> out_req high the cycle after the last bit; out_data=0xA5C30F81 (field3=0xA5, field0=0x81); out_req low 1 cycle after ack; overrun=0.
2. Same word with din_valid low on alternate cycles and 5 valid bits before frame_start -> pre-frame bits ignored; out_data=0xA5C30F81; latency measured from the last valid bit is still 1 cycle.
3. Two back-to-back frames 0x12345678, 0x9ABCDEF0; out_ack withheld until the second word completes, acked on that exact edge -> first word consumed, second presented after a 1-cycle req-low gap; overrun=0.
4. Three frames with out_ack never asserted -> out_data stays 0x(first word); overrun rises on the edge the second word completes and remains 1 after the third.
5. 10 bits of a frame, then frame_start + 32 bits of 0x0000FFFF -> frame_err single-cycle pulse; out_data=0x0000FFFF.
6. rst asserted for 1 cycle at bit 20 of a frame, and separately while out_req=1 -> all outputs 0 the next cycle; no word presented until a fresh full frame arrives.
